// File: rtl/hdc_classify_ctrl_if.sv
// Handshake bundle between the classifier sequencer, the query encoder,
// the similarity core and the result consumer.
interface hdc_classify_ctrl_if #(
    parameter int DIMENSIONS = 10000
);
    // Query port from the encoder
    logic                  q_valid;
    logic                  q_ready;
    logic [DIMENSIONS-1:0] q_hv;

    // Launch/completion path to the similarity core
    logic                  sim_en;
    logic [DIMENSIONS-1:0] sim_hv_test;
    logic                  sim_done;
    logic                  sim_label;

    // Result port to the consumer
    logic                  res_valid;
    logic                  res_ready;
    logic                  res_label;

    // Sequencer side
    modport master (
        input  q_valid, q_hv, sim_done, sim_label, res_ready,
        output q_ready, sim_en, sim_hv_test, res_valid, res_label
    );

    // Environment side (encoder, similarity core, consumer)
    modport slave (
        output q_valid, q_hv, sim_done, sim_label, res_ready,
        input  q_ready, sim_en, sim_hv_test, res_valid, res_label
    );
endinterface

// File: rtl/hdc_classify_ctrl.sv
// Sequencer for the HDC similarity classifier: accepts one query at a time,
// launches the similarity core, returns its label, and maintains a hysteresis
// seizure alarm plus a sticky watchdog on similarity completion.
module hdc_classify_ctrl #(
    parameter int DIMENSIONS = 10000,
    parameter int ALARM_ON   = 3,
    parameter int ALARM_OFF  = 5,
    parameter int TIMEOUT    = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    hdc_classify_ctrl_if.master    bus,
    output logic                   alarm,
    output logic                   timeout_err,
    output logic [15:0]            win_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    localparam int WD_W = $clog2(TIMEOUT);
    localparam int SR_W = $clog2(ALARM_ON + 1);
    localparam int NR_W = $clog2(ALARM_OFF + 1);

    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [SR_W:0]   SR_MAX  = (SR_W + 1)'(ALARM_ON);
    localparam logic [NR_W:0]   NR_MAX  = (NR_W + 1)'(ALARM_OFF);

    logic [1:0]            state_q,     state_d;
    logic [DIMENSIONS-1:0] hv_q,        hv_d;
    logic                  res_valid_q, res_valid_d;
    logic                  res_label_q, res_label_d;
    logic                  alarm_q,     alarm_d;
    logic                  tmo_q,       tmo_d;
    logic [15:0]           win_q,       win_d;
    logic [WD_W-1:0]       wd_q,        wd_d;
    logic [SR_W-1:0]       seiz_run_q,  seiz_run_d;
    logic [NR_W-1:0]       non_run_q,   non_run_d;

    logic [SR_W:0]         seiz_inc;
    logic [NR_W:0]         non_inc;

    // Ready is a decode of the state register, held low while reset is applied
    assign bus.q_ready     = (state_q == S_IDLE) && !rst;
    assign bus.sim_en      = (state_q == S_START);
    assign bus.sim_hv_test = hv_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_label   = res_label_q;
    assign alarm           = alarm_q;
    assign timeout_err     = tmo_q;
    assign win_count       = win_q;

    // Next-state logic for the sequencer, watchdog, run counters and alarm
    always_comb begin
        state_d     = state_q;
        hv_d        = hv_q;
        res_valid_d = res_valid_q;
        res_label_d = res_label_q;
        alarm_d     = alarm_q;
        tmo_d       = tmo_q;
        win_d       = win_q;
        wd_d        = wd_q;
        seiz_run_d  = seiz_run_q;
        non_run_d   = non_run_q;
        seiz_inc    = {1'b0, seiz_run_q} + 1'b1;
        non_inc     = {1'b0, non_run_q} + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (bus.q_valid) begin
                    hv_d    = bus.q_hv;
                    state_d = S_START;
                end
            end

            S_START: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (bus.sim_done) begin
                    res_label_d = bus.sim_label;
                    res_valid_d = 1'b1;
                    if (win_q != 16'hFFFF) begin
                        win_d = win_q + 16'd1;
                    end
                    if (bus.sim_label) begin
                        non_run_d = '0;
                        if (seiz_inc >= SR_MAX) begin
                            seiz_run_d = SR_MAX[SR_W-1:0];
                            alarm_d    = 1'b1;
                        end else begin
                            seiz_run_d = seiz_inc[SR_W-1:0];
                        end
                    end else begin
                        seiz_run_d = '0;
                        if (non_inc >= NR_MAX) begin
                            non_run_d = NR_MAX[NR_W-1:0];
                            alarm_d   = 1'b0;
                        end else begin
                            non_run_d = non_inc[NR_W-1:0];
                        end
                    end
                    state_d = S_HOLD;
                end else if (wd_q == WD_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end

            S_HOLD: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hv_q        <= '0;
            res_valid_q <= 1'b0;
            res_label_q <= 1'b0;
            alarm_q     <= 1'b0;
            tmo_q       <= 1'b0;
            win_q       <= '0;
            wd_q        <= '0;
            seiz_run_q  <= '0;
            non_run_q   <= '0;
        end else begin
            state_q     <= state_d;
            hv_q        <= hv_d;
            res_valid_q <= res_valid_d;
            res_label_q <= res_label_d;
            alarm_q     <= alarm_d;
            tmo_q       <= tmo_d;
            win_q       <= win_d;
            wd_q        <= wd_d;
            seiz_run_q  <= seiz_run_d;
            non_run_q   <= non_run_d;
        end
    end

endmodule

// File: tb/tb_hdc_classify_ctrl.sv
// Self-checking bench for hdc_classify_ctrl: table-driven alarm hysteresis
// sequence plus directed sequences for backpressure, watchdog, coincident
// done/timeout and reset during WAIT.
module tb_hdc_classify_ctrl;

    localparam int DIM  = 64;
    localparam int AON  = 3;
    localparam int AOFF = 5;
    localparam int TMO  = 16;

    typedef struct {
        logic        label;
        int          latency;
        int          readyDelay;
        logic        expAlarm;
        logic [15:0] expWin;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        alarm;
    logic        timeoutErr;
    logic [15:0] winCount;

    int compared   = 0;
    int mismatched = 0;

    vec_t vecs[16];

    hdc_classify_ctrl_if #(.DIMENSIONS(DIM)) bus ();

    hdc_classify_ctrl #(
        .DIMENSIONS (DIM),
        .ALARM_ON   (AON),
        .ALARM_OFF  (AOFF),
        .TIMEOUT    (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .alarm       (alarm),
        .timeout_err (timeoutErr),
        .win_count   (winCount)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Hard stop in case a sequence stalls
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish, required finish before limit");
        $fatal(1, "[TB] global timeout");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic qValid, input logic [DIM-1:0] qHv, input logic simDone,
                                 input logic simLabel, input logic resReady);
        bus.q_valid   = qValid;
        bus.q_hv      = qHv;
        bus.sim_done  = simDone;
        bus.sim_label = simLabel;
        bus.res_ready = resReady;
    endtask

    task automatic checkReset();
        checkOutput("rst_q_ready",     64'(bus.q_ready),     64'd0);
        checkOutput("rst_sim_en",      64'(bus.sim_en),      64'd0);
        checkOutput("rst_sim_hv_test", 64'(bus.sim_hv_test), 64'd0);
        checkOutput("rst_res_valid",   64'(bus.res_valid),   64'd0);
        checkOutput("rst_res_label",   64'(bus.res_label),   64'd0);
        checkOutput("rst_alarm",       64'(alarm),           64'd0);
        checkOutput("rst_timeout_err", 64'(timeoutErr),      64'd0);
        checkOutput("rst_win_count",   64'(winCount),        64'd0);
    endtask

    // One full query: handshake, done after 'latency' cycles, result held
    // for 'readyDelay' cycles of backpressure, then consumed.
    task automatic runQuery(input logic [DIM-1:0] hv, input logic label, input int latency,
                            input int readyDelay, input logic holdValid, input logic expAlarm,
                            input logic [15:0] expWin, input logic expTmo);
        checkOutput("q_ready_idle", 64'(bus.q_ready), 64'd1);
        applyStimulus(1'b1, hv, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("sim_en_start",  64'(bus.sim_en),      64'd1);
        checkOutput("sim_hv_test",   64'(bus.sim_hv_test), 64'(hv));
        checkOutput("q_ready_start", 64'(bus.q_ready),     64'd0);
        applyStimulus(1'b0, ~hv, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= latency; i++) begin
            @(negedge clk);
            checkOutput("sim_en_wait",    64'(bus.sim_en),    64'd0);
            checkOutput("res_valid_wait", 64'(bus.res_valid), 64'd0);
        end
        applyStimulus(1'b0, ~hv, 1'b1, label, 1'b0);
        @(negedge clk);
        applyStimulus(holdValid, ~hv, 1'b0, 1'b0, 1'b0);
        checkOutput("res_valid",   64'(bus.res_valid),   64'd1);
        checkOutput("res_label",   64'(bus.res_label),   64'(label));
        checkOutput("alarm",       64'(alarm),           64'(expAlarm));
        checkOutput("win_count",   64'(winCount),        64'(expWin));
        checkOutput("timeout_err", 64'(timeoutErr),      64'(expTmo));
        checkOutput("hv_held",     64'(bus.sim_hv_test), 64'(hv));
        for (int i = 0; i < readyDelay; i++) begin
            @(negedge clk);
            checkOutput("hold_res_valid", 64'(bus.res_valid),   64'd1);
            checkOutput("hold_res_label", 64'(bus.res_label),   64'(label));
            checkOutput("hold_q_ready",   64'(bus.q_ready),     64'd0);
            checkOutput("hold_sim_en",    64'(bus.sim_en),      64'd0);
            checkOutput("hold_hv",        64'(bus.sim_hv_test), 64'(hv));
        end
        applyStimulus(holdValid, ~hv, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, ~hv, 1'b0, 1'b0, 1'b0);
        checkOutput("res_valid_clear", 64'(bus.res_valid), 64'd0);
        checkOutput("q_ready_after",   64'(bus.q_ready),   64'd1);
        checkOutput("sim_en_after",    64'(bus.sim_en),    64'd0);
    endtask

    // Main test sequence
    initial begin
        logic [DIM-1:0] hv;
        logic [DIM-1:0] pattern;
        int             waitCycles;
        logic           sawValid;

        pattern = {8{8'hA5}};

        vecs[0]  = '{1'b1, 1, 0, 1'b0, 16'd1};
        vecs[1]  = '{1'b1, 2, 1, 1'b0, 16'd2};
        vecs[2]  = '{1'b0, 3, 0, 1'b0, 16'd3};
        vecs[3]  = '{1'b1, 4, 2, 1'b0, 16'd4};
        vecs[4]  = '{1'b1, 1, 0, 1'b0, 16'd5};
        vecs[5]  = '{1'b1, 6, 1, 1'b1, 16'd6};
        vecs[6]  = '{1'b0, 2, 0, 1'b1, 16'd7};
        vecs[7]  = '{1'b0, 3, 2, 1'b1, 16'd8};
        vecs[8]  = '{1'b0, 1, 0, 1'b1, 16'd9};
        vecs[9]  = '{1'b0, 5, 1, 1'b1, 16'd10};
        vecs[10] = '{1'b1, 2, 0, 1'b1, 16'd11};
        vecs[11] = '{1'b0, 3, 0, 1'b1, 16'd12};
        vecs[12] = '{1'b0, 4, 1, 1'b1, 16'd13};
        vecs[13] = '{1'b0, 1, 0, 1'b1, 16'd14};
        vecs[14] = '{1'b0, 2, 2, 1'b1, 16'd15};
        vecs[15] = '{1'b0, 3, 0, 1'b0, 16'd16};

        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checkReset();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("q_ready_post_reset", 64'(bus.q_ready), 64'd1);

        $display("[TB] single query");
        runQuery(pattern, 1'b1, 5, 0, 1'b0, 1'b0, 16'd1, 1'b0);

        $display("[TB] backpressure");
        runQuery(~pattern, 1'b0, 3, 10, 1'b1, 1'b0, 16'd2, 1'b0);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] alarm hysteresis table");
        for (int v = 0; v < 16; v++) begin
            hv = pattern ^ DIM'(v * 32'h01010101);
            runQuery(hv, vecs[v].label, vecs[v].latency, vecs[v].readyDelay, 1'b0,
                     vecs[v].expAlarm, vecs[v].expWin, 1'b0);
        end

        $display("[TB] done coincident with watchdog expiry");
        runQuery(pattern, 1'b0, TMO, 0, 1'b0, 1'b0, 16'd17, 1'b0);

        $display("[TB] watchdog");
        applyStimulus(1'b1, pattern, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("wd_sim_en", 64'(bus.sim_en), 64'd1);
        applyStimulus(1'b0, pattern, 1'b0, 1'b0, 1'b0);
        waitCycles = 0;
        sawValid   = 1'b0;
        while (bus.q_ready !== 1'b1 && waitCycles < 40) begin
            @(negedge clk);
            waitCycles++;
            if (bus.res_valid === 1'b1) sawValid = 1'b1;
        end
        checkOutput("wd_cycles_to_idle", 64'(waitCycles), 64'd17);
        checkOutput("wd_timeout_err",    64'(timeoutErr), 64'd1);
        checkOutput("wd_no_res_valid",   64'(sawValid),   64'd0);
        checkOutput("wd_win_count",      64'(winCount),   64'd17);
        checkOutput("wd_alarm",          64'(alarm),      64'd0);

        runQuery(~pattern, 1'b1, 2, 0, 1'b0, 1'b0, 16'd18, 1'b1);
        runQuery(pattern,  1'b1, 3, 0, 1'b0, 1'b0, 16'd19, 1'b1);
        runQuery(~pattern, 1'b1, 1, 0, 1'b0, 1'b1, 16'd20, 1'b1);

        $display("[TB] reset during WAIT");
        applyStimulus(1'b1, pattern, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, pattern, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkReset();
        rst = 1'b0;
        applyStimulus(1'b0, pattern, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, pattern, 1'b0, 1'b0, 1'b0);
        checkOutput("stale_res_valid", 64'(bus.res_valid), 64'd0);
        checkOutput("stale_q_ready",   64'(bus.q_ready),   64'd1);
        checkOutput("stale_win_count", 64'(winCount),      64'd0);
        checkOutput("stale_alarm",     64'(alarm),         64'd0);
        @(negedge clk);
        checkOutput("stale_res_valid2", 64'(bus.res_valid), 64'd0);

        runQuery(pattern, 1'b0, 2, 0, 1'b0, 1'b0, 16'd1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
